hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage MIPS core. Drives the stall and flush
//  controls of the IF/ID and ID/EX pipeline registers, and selects EX-stage operand forwarding.
//  Detects load-use hazards and taken-branch control hazards.
//  Sequences a multi-cycle mult/div unit, stalling ID while that unit is busy.
//  Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  MD_CYCLES  4   mult/div latency in cycles (>=2)
//  CNT_W      16  width of stall performance counter
// PORTS
//  clk_i            in   1      clock, all state updates on rising edge
//  reset_ni         in   1      synchronous reset, active low
//  rs_id5           in   5      ID-stage source reg A
//  rt_id5           in   5      ID-stage source reg B
//  branch_taken_id  in   1      branch in ID resolved taken
//  md_start_id      in   1      ID instruction is mult/div
//  md_read_id       in   1      ID instruction is mfhi/mflo
//  rs_ex5           in   5      EX-stage source reg A
//  rt_ex5           in   5      EX-stage source reg B
//  write_reg_ex5    in   5      EX destination reg
//  enable_wreg_ex   in   1      EX writes regfile
//  mem_to_reg_ex    in   1      EX instruction is a load
//  write_reg_mem5   in   5      MEM destination reg
//  enable_wreg_mem  in   1      MEM writes regfile
//  write_reg_wb5    in   5      WB destination reg
//  enable_wreg_wb   in   1      WB writes regfile
//  stall_if_o       out  1      hold PC
//  stall_id_o       out  1      hold IF/ID register
//  flush_ifid_o     out  1      clear IF/ID register
//  flush_idex_o     out  1      clear ID/EX register (insert bubble)
//  fwd_a_ex2        out  2      EX operand A select: 00 regfile, 01 WB, 10 MEM
//  fwd_b_ex2        out  2      EX operand B select, same encoding
//  md_busy_o        out  1      mult/div in progress
//  md_done_o        out  1      last busy cycle, HI/LO valid
//  stall_cnt_o      out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  - Reset (reset_ni=0 at a clock edge): FSM->IDLE, md counter=0, stall_cnt_o=0.
//    While reset_ni=0, all stall/flush outputs=0, fwd_*=00, md_busy_o=md_done_o=0.
//  - Load-use: lu = mem_to_reg_ex & enable_wreg_ex & (write_reg_ex5!=0)
//    & (write_reg_ex5==rs_id5 | write_reg_ex5==rt_id5). Combinational, same cycle.
//  - FSM states IDLE, MD_BUSY:
//    IDLE -> MD_BUSY on an edge with md_start_id=1 and stall=0; counter loads MD_CYCLES-1.
//    MD_BUSY: counter decrements each cycle. md_done_o=1 when counter==0.
//    MD_BUSY -> IDLE on the edge after the counter==0 cycle.
//    Net effect: a start accepted at edge k gives md_busy_o=1 for exactly MD_CYCLES cycles.
//  - md hazard: mh = md_busy_o & ~md_done_o & (md_read_id | md_start_id).
//    The done cycle does not stall, so back-to-back issue is allowed.
//  - stall = lu | mh. Then stall_if_o = stall_id_o = stall, and flush_idex_o = stall.
//  - flush_ifid_o = branch_taken_id & ~stall.
//    Stall wins: the branch is held in ID and flushes once the stall clears.
//  - Forwarding (combinational), for A with rs_ex5 and for B with rt_ex5:
//    10 if enable_wreg_mem & write_reg_mem5!=0 & match;
//    else 01 if enable_wreg_wb & write_reg_wb5!=0 & match;
//    else 00. MEM has priority over WB. Reg 0 is never forwarded.
//  - stall_cnt_o increments on each edge with stall=1 and saturates at 2^CNT_W-1.
//  - Reset asserted in MD_BUSY aborts the operation; no md_done_o pulse is produced.
// TESTING
//  1 write_reg_ex5=8, mem_to_reg_ex=1, enable_wreg_ex=1, rs_id5=8
//    -> stall_if/id=1 and flush_idex=1 for that cycle only.
//    Same stimulus with write_reg_ex5=0 -> all stall/flush outputs 0.
//  2 rs_ex5=9, MEM and WB both writing reg 9 -> fwd_a_ex2=10.
//    Disable MEM -> 01. rs_ex5=0 -> 00.
//  3 MD_CYCLES=4, md_start_id pulse at edge 0 -> md_busy_o=1 in cycles 1-4, md_done_o=1 in cycle 4.
//    md_read_id held from cycle 1 -> stall=1 in cycles 1-3, 0 in cycle 4.
//  4 branch_taken_id=1 together with a load-use for one cycle -> flush_ifid=0, stall=1.
//    Next cycle, no load-use -> flush_ifid=1, stall=0.
//  5 Reset at cycle 2 of a mult/div -> next cycle md_busy_o=0 and stall_cnt_o=0.
//    md_done_o never pulses.
//  6 CNT_W=4, 20 consecutive load-use stall cycles -> stall_cnt_o=15, and it stays 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS pipeline: load-use and mult/div stalls,
// branch flush, EX operand forwarding and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [4:0]       rs_id5,
  input  logic [4:0]       rt_id5,
  input  logic             branch_taken_id,
  input  logic             md_start_id,
  input  logic             md_read_id,
  input  logic [4:0]       rs_ex5,
  input  logic [4:0]       rt_ex5,
  input  logic [4:0]       write_reg_ex5,
  input  logic             enable_wreg_ex,
  input  logic             mem_to_reg_ex,
  input  logic [4:0]       write_reg_mem5,
  input  logic             enable_wreg_mem,
  input  logic [4:0]       write_reg_wb5,
  input  logic             enable_wreg_wb,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic [1:0]       fwd_a_ex2,
  output logic [1:0]       fwd_b_ex2,
  output logic             md_busy_o,
  output logic             md_done_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int MDC_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
  localparam logic [MDC_W-1:0] MD_LOAD = MDC_W'(MD_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu, mh, stall, md_busy, md_done, md_accept;

  // MEM result is newer than WB, so it wins; r0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       mem_en,
                                         input logic [4:0] mem_reg,
                                         input logic       wb_en,
                                         input logic [4:0] wb_reg);
    if (mem_en && (mem_reg != 5'd0) && (mem_reg == src)) return 2'b10;
    else if (wb_en && (wb_reg != 5'd0) && (wb_reg == src)) return 2'b01;
    else return 2'b00;
  endfunction

  always_comb begin
    lu = mem_to_reg_ex & enable_wreg_ex & (write_reg_ex5 != 5'd0)
       & ((write_reg_ex5 == rs_id5) | (write_reg_ex5 == rt_id5));
    md_busy = (state_q == MD_BUSY);
    md_done = md_busy & (md_cnt_q == '0);
    mh      = md_busy & ~md_done & (md_read_id | md_start_id);
    stall   = reset_ni & (lu | mh);
    // A start can be taken while idle or in the done cycle (back-to-back issue).
    md_accept = md_start_id & ~stall & (~md_busy | md_done);

    stall_if_o   = stall;
    stall_id_o   = stall;
    flush_idex_o = stall;
    flush_ifid_o = reset_ni & branch_taken_id & ~stall;
    fwd_a_ex2    = reset_ni ? fwd_sel(rs_ex5, enable_wreg_mem, write_reg_mem5,
                                      enable_wreg_wb, write_reg_wb5) : 2'b00;
    fwd_b_ex2    = reset_ni ? fwd_sel(rt_ex5, enable_wreg_mem, write_reg_mem5,
                                      enable_wreg_wb, write_reg_wb5) : 2'b00;
    md_busy_o    = reset_ni & md_busy;
    md_done_o    = reset_ni & md_done;
    stall_cnt_o  = stall_cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      IDLE: begin
        if (md_accept) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == '0) begin
          if (md_accept) begin
            md_cnt_d = MD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int MDC  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic [4:0]    rs_id5, rt_id5, rs_ex5, rt_ex5;
  logic [4:0]    write_reg_ex5, write_reg_mem5, write_reg_wb5;
  logic          branch_taken_id, md_start_id, md_read_id;
  logic          enable_wreg_ex, mem_to_reg_ex, enable_wreg_mem, enable_wreg_wb;
  logic          stall_if_o, stall_id_o, flush_ifid_o, flush_idex_o;
  logic [1:0]    fwd_a_ex2, fwd_b_ex2;
  logic          md_busy_o, md_done_o;
  logic [CW-1:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  // Reference state: busy cycles still to come (incl. current) and stall count.
  int busy_left = 0;
  int cnt_m     = 0;

  hazard_ctrl #(.MD_CYCLES(MDC), .CNT_W(CW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .rs_id5(rs_id5), .rt_id5(rt_id5),
    .branch_taken_id(branch_taken_id), .md_start_id(md_start_id), .md_read_id(md_read_id),
    .rs_ex5(rs_ex5), .rt_ex5(rt_ex5),
    .write_reg_ex5(write_reg_ex5), .enable_wreg_ex(enable_wreg_ex), .mem_to_reg_ex(mem_to_reg_ex),
    .write_reg_mem5(write_reg_mem5), .enable_wreg_mem(enable_wreg_mem),
    .write_reg_wb5(write_reg_wb5), .enable_wreg_wb(enable_wreg_wb),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
    .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o),
    .fwd_a_ex2(fwd_a_ex2), .fwd_b_ex2(fwd_b_ex2),
    .md_busy_o(md_busy_o), .md_done_o(md_done_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int fwd_ref(input logic [4:0] src);
    if (!reset_ni || src == 0) return 0;
    if (enable_wreg_mem && write_reg_mem5 == src) return 2;
    if (enable_wreg_wb && write_reg_wb5 == src) return 1;
    return 0;
  endfunction

  // Called just after a falling edge with inputs applied; checks, then advances one clock.
  task automatic step();
    bit lu, busy, done, stall, start_ok;
    #1;
    lu    = reset_ni && mem_to_reg_ex && enable_wreg_ex && write_reg_ex5 != 0 &&
            (write_reg_ex5 == rs_id5 || write_reg_ex5 == rt_id5);
    busy  = reset_ni && busy_left > 0;
    done  = reset_ni && busy_left == 1;
    stall = lu || (busy && !done && (md_read_id || md_start_id));
    chk("stall_if", int'(stall_if_o), int'(stall));
    chk("stall_id", int'(stall_id_o), int'(stall));
    chk("flush_idex", int'(flush_idex_o), int'(stall));
    chk("flush_ifid", int'(flush_ifid_o), int'(reset_ni && branch_taken_id && !stall));
    chk("fwd_a", int'(fwd_a_ex2), fwd_ref(rs_ex5));
    chk("fwd_b", int'(fwd_b_ex2), fwd_ref(rt_ex5));
    chk("md_busy", int'(md_busy_o), int'(busy));
    chk("md_done", int'(md_done_o), int'(done));
    chk("stall_cnt", int'(stall_cnt_o), cnt_m);
    $display("cyc=%0d rst_n=%0b stall=%0b fl_ifid=%0b fa=%0d fb=%0d busy=%0b done=%0b cnt=%0d",
             cyc, reset_ni, stall_if_o, flush_ifid_o, fwd_a_ex2, fwd_b_ex2,
             md_busy_o, md_done_o, stall_cnt_o);
    @(posedge clk_i);
    if (!reset_ni) begin
      busy_left = 0;
      cnt_m     = 0;
    end else begin
      if (stall && cnt_m < CMAX) cnt_m++;
      start_ok = md_start_id && !stall && busy_left <= 1;
      if (busy_left > 0) busy_left--;
      if (start_ok) busy_left = MDC;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    rs_id5 = 0; rt_id5 = 0; rs_ex5 = 0; rt_ex5 = 0;
    write_reg_ex5 = 0; write_reg_mem5 = 0; write_reg_wb5 = 0;
    branch_taken_id = 0; md_start_id = 0; md_read_id = 0;
    enable_wreg_ex = 0; mem_to_reg_ex = 0; enable_wreg_mem = 0; enable_wreg_wb = 0;
  endtask

  task automatic set_lu(input bit on);
    write_reg_ex5 = 5'd8; rs_id5 = on ? 5'd8 : 5'd3;
    mem_to_reg_ex = 1; enable_wreg_ex = 1;
  endtask

  initial begin
    reset_ni = 0;
    idle_inputs();
    @(posedge clk_i);
    @(negedge clk_i);
    step();                        // reset held: everything low
    reset_ni = 1;

    // Load-use stall, then destination r0 suppresses it.
    set_lu(1);
    #1 chk("t1_stall", int'(stall_if_o), 1);
    step();
    write_reg_ex5 = 0; rs_id5 = 0;
    #1 chk("t1_r0_flush", int'(flush_idex_o), 0);
    step();
    idle_inputs();

    // Forwarding priority.
    rs_ex5 = 9; write_reg_mem5 = 9; write_reg_wb5 = 9;
    enable_wreg_mem = 1; enable_wreg_wb = 1;
    #1 chk("t2_mem", int'(fwd_a_ex2), 2);
    step();
    enable_wreg_mem = 0;
    #1 chk("t2_wb", int'(fwd_a_ex2), 1);
    step();
    rs_ex5 = 0;
    #1 chk("t2_r0", int'(fwd_a_ex2), 0);
    step();
    idle_inputs();

    // Mult/div sequencing with an mfhi waiting on it.
    md_start_id = 1;
    step();
    md_start_id = 0; md_read_id = 1;
    for (int i = 0; i < MDC; i++) begin
      #1;
      chk("t3_busy", int'(md_busy_o), 1);
      chk("t3_done", int'(md_done_o), int'(i == MDC - 1));
      chk("t3_stall", int'(stall_id_o), int'(i < MDC - 1));
      step();
    end
    md_read_id = 0;
    #1 chk("t3_idle", int'(md_busy_o), 0);
    step();

    // Stall defers the branch flush by one cycle.
    set_lu(1); branch_taken_id = 1;
    #1 chk("t4_noflush", int'(flush_ifid_o), 0);
    step();
    set_lu(0);
    #1 chk("t4_flush", int'(flush_ifid_o), 1);
    chk("t4_nostall", int'(stall_if_o), 0);
    step();
    idle_inputs();

    // Reset in the middle of a mult/div.
    set_lu(1);
    step();
    idle_inputs(); md_start_id = 1;
    step();
    md_start_id = 0;
    step();
    reset_ni = 0;
    step();
    reset_ni = 1;
    #1 chk("t5_busy", int'(md_busy_o), 0);
    chk("t5_cnt", int'(stall_cnt_o), 0);
    for (int i = 0; i < MDC; i++) step();

    // Counter saturation.
    set_lu(1);
    for (int i = 0; i < 20; i++) step();
    #1 chk("t6_sat", int'(stall_cnt_o), CMAX);
    step();
    #1 chk("t6_hold", int'(stall_cnt_o), CMAX);
    idle_inputs();
    step();

    // Random traffic over a small register range so matches are common.
    for (int n = 0; n < 400; n++) begin
      reset_ni        = ($urandom_range(0, 49) != 0);
      rs_id5          = 5'($urandom_range(0, 3));
      rt_id5          = 5'($urandom_range(0, 3));
      rs_ex5          = 5'($urandom_range(0, 3));
      rt_ex5          = 5'($urandom_range(0, 3));
      write_reg_ex5   = 5'($urandom_range(0, 3));
      write_reg_mem5  = 5'($urandom_range(0, 3));
      write_reg_wb5   = 5'($urandom_range(0, 3));
      enable_wreg_ex  = 1'($urandom_range(0, 1));
      mem_to_reg_ex   = ($urandom_range(0, 3) == 0);
      enable_wreg_mem = 1'($urandom_range(0, 1));
      enable_wreg_wb  = 1'($urandom_range(0, 1));
      branch_taken_id = ($urandom_range(0, 3) == 0);
      md_start_id     = ($urandom_range(0, 3) == 0);
      md_read_id      = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
